brq_wb_stage: RTL and testbench
===============================

Name: brq_wb_stage

Overview:
Writeback stage that owns the single register-file write port. It merges single-cycle execute results with load responses from the LSU, registers the chosen write for one cycle, and drives the flip-flop register file. It tracks one outstanding load for RAW/WAW hazard stalls, and forwards the in-flight writeback onto both read operands so decode sees up-to-date values.

Parameters:
DataWidth, 32, width of register data
RV32E, 0, 1 = 16 registers; address compares use bits [3:0] only and bit 4 is ignored

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ex_valid_i  in  1  execute result offered this cycle
ex_we_i  in  1  execute result writes rd
ex_waddr_i  in  5  execute destination
ex_wdata_i  in  DataWidth  execute result
ex_ready_o  out  1  execute result accepted this cycle (combinational)
lsu_load_issue_i  in  1  load request issued to memory this cycle
lsu_load_rd_i  in  5  destination of issued load
lsu_rvalid_i  in  1  load response valid
lsu_rdata_i  in  DataWidth  load response data
lsu_err_i  in  1  load response is an error (qualified by lsu_rvalid_i)
lsu_busy_o  out  1  a load is outstanding; LSU must not issue
load_err_o  out  1  one-cycle pulse on error response
rf_we_o  out  1  register-file write enable (registered)
rf_waddr_o  out  5  register-file write address (registered)
rf_wdata_o  out  DataWidth  register-file write data (registered)
raddr_a_i  in  5  decode read address A
raddr_b_i  in  5  decode read address B
rdata_a_i  in  DataWidth  register-file read data A
rdata_b_i  in  DataWidth  register-file read data B
operand_a_o  out  DataWidth  forwarded operand A
operand_b_o  out  DataWidth  forwarded operand B
stall_id_o  out  1  decode must stall (RAW on pending load)

Behaviour:
- Reset (async, rst_ni low): FSM = IDLE, pend_rd = 0, rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, load_err_o = 0. Combinational outputs follow from this state.
- FSM IDLE:
  - lsu_load_issue_i -> WAIT_RSP, latch pend_rd = lsu_load_rd_i.
  - lsu_rvalid_i in IDLE is ignored; an assertion flags it.
- FSM WAIT_RSP:
  - lsu_rvalid_i -> IDLE.
  - lsu_load_issue_i is illegal (flagged by an assertion) and ignored.
  - An issue in the same cycle as the response is legal: stay in WAIT_RSP, latch the new pend_rd.
- lsu_busy_o = (state == WAIT_RSP) && !lsu_rvalid_i.
- Write selection, priority order:
  1. Load response: lsu_rvalid_i && !lsu_err_i && pend_rd != 0 -> write pend_rd / lsu_rdata_i.
  2. Execute: ex_valid_i && ex_ready_o && ex_we_i && ex_waddr_i != 0.
  3. Otherwise no write.
- The selected write is registered: rf_we_o/rf_waddr_o/rf_wdata_o update at the next edge, so latency is exactly 1 cycle. The RF commits one edge later.
- ex_ready_o = !(state == WAIT_RSP && lsu_rvalid_i) && !(state == WAIT_RSP && ex_we_i && ex_waddr_i == pend_rd && pend_rd != 0).
  - The first term is the port collision; the second is WAW ordering.
- Writes to x0 never assert rf_we_o. Address compares honour RV32E.
- Error response: no RF write; load_err_o is high for the cycle after lsu_rvalid_i; FSM returns to IDLE.
- Forwarding:
  - operand_a_o = (rf_we_o && rf_waddr_o == raddr_a_i && raddr_a_i != 0) ? rf_wdata_o : rdata_a_i.
  - Operand B is identical.
- stall_id_o asserts when state == WAIT_RSP, pend_rd != 0, and either raddr_a_i or raddr_b_i equals pend_rd.
  - It is held even in the response cycle; it deasserts the cycle after, when forwarding supplies the data.
- Reset mid-load drops the pending load; any late lsu_rvalid_i arriving in IDLE is ignored.

Decomposition:
- Shared brq_pkg: wb_state_e {WB_IDLE, WB_WAIT_RSP}; the wb_req_t struct {we, waddr, wdata}.
- One sub-module, brq_wb_fwd: a purely combinational per-operand forward mux, instantiated twice.
- FSM, scoreboard and write register stay in the top module.

Test Plan:
- EX write x5 = 0xDEADBEEF with no load -> rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF one cycle later; raddr_a_i = 5 that cycle -> operand_a_o = 0xDEADBEEF.
- Load to x7, response 0x1234 three cycles later; raddr_b_i = 7 throughout -> stall_id_o high through the response cycle, low the next; rf write x7 = 0x1234 after 1 cycle; operand_b_o = 0x1234.
- Load response and EX write of x3 in the same cycle -> ex_ready_o = 0 and only the load write occurs; the EX write commits the following cycle.
- Load to x9 pending, EX writes x9 -> ex_ready_o = 0 until the response; the final RF value is the EX data.
- Error response -> no rf_we_o, load_err_o pulses once, FSM is IDLE and lsu_busy_o = 0.
- EX write of x0, and a load to x0 -> rf_we_o never asserts; stall_id_o stays 0 for raddr = 0. Separately, assert rst_ni during WAIT_RSP -> all registered outputs are 0 immediately.

Source files
------------

// File: rtl/brq_pkg.sv
// Shared types and address helpers for the writeback stage.
// Register addresses are 5 bits; in RV32E mode only bits [3:0] take part in compares.
package brq_pkg;

    localparam int unsigned WbDataW = 32;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_RSP = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic               we;
        logic [4:0]         waddr;
        logic [WbDataW-1:0] wdata;
    } wb_req_t;

    function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b,
                                     input logic rv32e);
        return rv32e ? (a[3:0] == b[3:0]) : (a == b);
    endfunction

    function automatic logic addr_nz(input logic [4:0] a, input logic rv32e);
        return rv32e ? (a[3:0] != 4'd0) : (a != 5'd0);
    endfunction

endpackage

// File: rtl/brq_wb_if.sv
// Bundle of execute, LSU, register-file and decode signals seen by the writeback stage.
// The stage itself uses the slave modport; its environment uses master.
interface brq_wb_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 ex_valid_i;
    logic                 ex_we_i;
    logic [4:0]           ex_waddr_i;
    logic [DataWidth-1:0] ex_wdata_i;
    logic                 ex_ready_o;
    logic                 lsu_load_issue_i;
    logic [4:0]           lsu_load_rd_i;
    logic                 lsu_rvalid_i;
    logic [DataWidth-1:0] lsu_rdata_i;
    logic                 lsu_err_i;
    logic                 lsu_busy_o;
    logic                 load_err_o;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic [4:0]           raddr_a_i;
    logic [4:0]           raddr_b_i;
    logic [DataWidth-1:0] rdata_a_i;
    logic [DataWidth-1:0] rdata_b_i;
    logic [DataWidth-1:0] operand_a_o;
    logic [DataWidth-1:0] operand_b_o;
    logic                 stall_id_o;

    modport slave (
        input  ex_valid_i, ex_we_i, ex_waddr_i, ex_wdata_i,
        input  lsu_load_issue_i, lsu_load_rd_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
        input  raddr_a_i, raddr_b_i, rdata_a_i, rdata_b_i,
        output ex_ready_o, lsu_busy_o, load_err_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output operand_a_o, operand_b_o, stall_id_o
    );

    modport master (
        output ex_valid_i, ex_we_i, ex_waddr_i, ex_wdata_i,
        output lsu_load_issue_i, lsu_load_rd_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
        output raddr_a_i, raddr_b_i, rdata_a_i, rdata_b_i,
        input  ex_ready_o, lsu_busy_o, load_err_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  operand_a_o, operand_b_o, stall_id_o
    );

endinterface

// File: rtl/brq_wb_fwd.sv
// Per-operand bypass: substitutes the in-flight writeback for the register-file read data
// when it targets the same non-zero register.
module brq_wb_fwd
    import brq_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [4:0]           raddr_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic [DataWidth-1:0] operand_o
);

    logic hit;

    assign hit       = we_i && addr_eq(waddr_i, raddr_i, RV32E) && addr_nz(raddr_i, RV32E);
    assign operand_o = hit ? wdata_i : rdata_i;

endmodule

// File: rtl/brq_wb_stage.sv
// Writeback stage: arbitrates load responses against execute results for the single RF
// write port, registers the winner for one cycle, tracks one outstanding load and forwards.
module brq_wb_stage
    import brq_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    brq_wb_if.slave   wb
);

    if (DataWidth != WbDataW) begin : g_width_check
        $error("brq_wb_stage: DataWidth must equal brq_pkg::WbDataW");
    end

    wb_state_e            state_q, state_d;
    logic [4:0]           pend_rd_q, pend_rd_d;
    wb_req_t              req_q, req_d;
    logic                 load_err_q, load_err_d;

    logic                 in_wait, rsp, pend_nz, waw_hit, ex_ready;
    logic                 stall;
    logic [DataWidth-1:0] operand_a, operand_b;

    // State register: FSM and the destination of the outstanding load
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= WB_IDLE;
            pend_rd_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
        end
    end

    // Next state: a response may retire the load while a new one issues in the same cycle
    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        case (state_q)
            WB_IDLE: begin
                if (wb.lsu_load_issue_i) begin
                    state_d   = WB_WAIT_RSP;
                    pend_rd_d = wb.lsu_load_rd_i;
                end
            end
            WB_WAIT_RSP: begin
                if (wb.lsu_rvalid_i) begin
                    if (wb.lsu_load_issue_i) begin
                        pend_rd_d = wb.lsu_load_rd_i;
                    end else begin
                        state_d = WB_IDLE;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Outputs: port arbitration, hazard detection and write selection
    always_comb begin
        in_wait    = (state_q == WB_WAIT_RSP);
        rsp        = in_wait && wb.lsu_rvalid_i;
        pend_nz    = addr_nz(pend_rd_q, RV32E);
        waw_hit    = in_wait && wb.ex_we_i && pend_nz
                     && addr_eq(wb.ex_waddr_i, pend_rd_q, RV32E);
        ex_ready   = !rsp && !waw_hit;
        stall      = in_wait && pend_nz
                     && (addr_eq(wb.raddr_a_i, pend_rd_q, RV32E)
                         || addr_eq(wb.raddr_b_i, pend_rd_q, RV32E));
        load_err_d = rsp && wb.lsu_err_i;
        req_d      = '0;
        if (rsp && !wb.lsu_err_i && pend_nz) begin
            req_d = '{we: 1'b1, waddr: pend_rd_q, wdata: wb.lsu_rdata_i};
        end else if (wb.ex_valid_i && ex_ready && wb.ex_we_i
                     && addr_nz(wb.ex_waddr_i, RV32E)) begin
            req_d = '{we: 1'b1, waddr: wb.ex_waddr_i, wdata: wb.ex_wdata_i};
        end
    end

    // Write register feeding the RF port and the bypass network
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            load_err_q <= load_err_d;
        end
    end

    brq_wb_fwd #(.DataWidth(DataWidth), .RV32E(RV32E)) u_fwd_a (
        .we_i      (req_q.we),
        .waddr_i   (req_q.waddr),
        .wdata_i   (req_q.wdata),
        .raddr_i   (wb.raddr_a_i),
        .rdata_i   (wb.rdata_a_i),
        .operand_o (operand_a)
    );

    brq_wb_fwd #(.DataWidth(DataWidth), .RV32E(RV32E)) u_fwd_b (
        .we_i      (req_q.we),
        .waddr_i   (req_q.waddr),
        .wdata_i   (req_q.wdata),
        .raddr_i   (wb.raddr_b_i),
        .rdata_i   (wb.rdata_b_i),
        .operand_o (operand_b)
    );

    assign wb.ex_ready_o  = ex_ready;
    assign wb.lsu_busy_o  = in_wait && !wb.lsu_rvalid_i;
    assign wb.load_err_o  = load_err_q;
    assign wb.rf_we_o     = req_q.we;
    assign wb.rf_waddr_o  = req_q.waddr;
    assign wb.rf_wdata_o  = req_q.wdata;
    assign wb.operand_a_o = operand_a;
    assign wb.operand_b_o = operand_b;
    assign wb.stall_id_o  = stall;

    // A response with nothing outstanding, or a second issue while waiting, is a protocol error
    a_no_rsp_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(state_q == WB_IDLE && wb.lsu_rvalid_i));
    a_no_issue_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(state_q == WB_WAIT_RSP && wb.lsu_load_issue_i && !wb.lsu_rvalid_i));

endmodule

// File: tb/tb_brq_wb_stage.sv
// Scoreboard bench for brq_wb_stage: directed scenarios plus random legal traffic checked
// against a transaction-level model of the single outstanding load and the write port.
module tb_brq_wb_stage;
    import brq_pkg::*;

    logic clk;
    logic rst_n;

    brq_wb_if #(.DataWidth(32)) wb ();

    brq_wb_stage #(.DataWidth(32), .RV32E(1'b0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .wb     (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    bit  mon_en = 1'b0;

    // model of architectural state visible to the bench
    bit          pend_v;
    logic [4:0]  pend_rd;
    bit          fw_we;
    logic [4:0]  fw_addr;
    logic [31:0] fw_data;
    bit          exp_err;
    // expectations for the cycle currently being driven
    bit          e_ready, e_busy, e_stall;
    bit          nx_we, nx_err, nx_pend_v;
    logic [4:0]  nx_addr, nx_pend_rd;
    logic [31:0] nx_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit exv, input bit exwe, input logic [4:0] exa,
                         input logic [31:0] exd, input bit iss, input logic [4:0] lrd,
                         input bit rv, input bit er, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb);
        bit resp;
        bit blocked_by_load;
        wb.ex_valid_i       = exv;
        wb.ex_we_i          = exwe;
        wb.ex_waddr_i       = exa;
        wb.ex_wdata_i       = exd;
        wb.lsu_load_issue_i = iss;
        wb.lsu_load_rd_i    = lrd;
        wb.lsu_rvalid_i     = rv;
        wb.lsu_err_i        = er;
        wb.lsu_rdata_i      = ld;
        wb.raddr_a_i        = ra;
        wb.raddr_b_i        = rb;
        wb.rdata_a_i        = $urandom;
        wb.rdata_b_i        = $urandom;
        resp = pend_v && rv;
        // an EX write must wait while the port is taken or an older load owns the same rd
        blocked_by_load = pend_v && exwe && (pend_rd != 0) && (exa == pend_rd);
        e_ready = !resp && !blocked_by_load;
        e_busy  = pend_v && !rv;
        e_stall = pend_v && (pend_rd != 0) && (ra == pend_rd || rb == pend_rd);
        nx_we   = 1'b0;
        nx_addr = 5'd0;
        nx_data = 32'd0;
        if (resp && !er && pend_rd != 0) begin
            nx_we = 1'b1; nx_addr = pend_rd; nx_data = ld;
        end else if (exv && e_ready && exwe && exa != 0) begin
            nx_we = 1'b1; nx_addr = exa; nx_data = exd;
        end
        if (nx_we) sb.push_back('{cyc + 1, nx_addr, nx_data});
        nx_err     = resp && er;
        nx_pend_v  = resp ? iss : (pend_v || iss);
        nx_pend_rd = (iss && (!pend_v || resp)) ? lrd : pend_rd;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 0, 32'd0, ra, rb);
    endtask

    task automatic step();
        logic [31:0] exp_a, exp_b;
        @(negedge clk);
        exp_a = (fw_we && fw_addr == wb.raddr_a_i && wb.raddr_a_i != 0) ? fw_data : wb.rdata_a_i;
        exp_b = (fw_we && fw_addr == wb.raddr_b_i && wb.raddr_b_i != 0) ? fw_data : wb.rdata_b_i;
        chk("ex_ready", 32'(wb.ex_ready_o), 32'(e_ready));
        chk("lsu_busy", 32'(wb.lsu_busy_o), 32'(e_busy));
        chk("stall_id", 32'(wb.stall_id_o), 32'(e_stall));
        chk("operand_a", wb.operand_a_o, exp_a);
        chk("operand_b", wb.operand_b_o, exp_b);
        @(posedge clk);
        #1;
        pend_v  = nx_pend_v;
        pend_rd = nx_pend_rd;
        fw_we   = nx_we;
        fw_addr = nx_addr;
        fw_data = nx_data;
        exp_err = nx_err;
        cyc++;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an RF write
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("load_err", 32'(wb.load_err_o), 32'(exp_err));
            if (wb.rf_we_o) begin
                if (sb.size() == 0) begin
                    chk("rf_we_unexpected", 32'(wb.rf_we_o), 32'd0);
                end else begin
                    chk("rf_waddr", 32'(wb.rf_waddr_o), 32'(sb[0].addr));
                    chk("rf_wdata", wb.rf_wdata_o, sb[0].data);
                    chk("rf_latency", 32'(cyc), 32'(sb[0].due));
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("rf_we_missing", 32'(wb.rf_we_o), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit rv, iss;
        rst_n = 1'b0;
        idle(5'd0, 5'd0);
        pend_v = 0; pend_rd = 0; fw_we = 0; fw_addr = 0; fw_data = 0; exp_err = 0;
        #3;
        chk("rst_rf_we", 32'(wb.rf_we_o), 32'd0);
        chk("rst_rf_waddr", 32'(wb.rf_waddr_o), 32'd0);
        chk("rst_rf_wdata", wb.rf_wdata_o, 32'd0);
        chk("rst_load_err", 32'(wb.load_err_o), 32'd0);
        chk("rst_busy", 32'(wb.lsu_busy_o), 32'd0);
        chk("rst_stall", 32'(wb.stall_id_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // EX write x5, then read it back through the bypass
        drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
        step();
        chk("t1_rf_we", 32'(wb.rf_we_o), 32'd1);
        chk("t1_rf_waddr", 32'(wb.rf_waddr_o), 32'd5);
        chk("t1_rf_wdata", wb.rf_wdata_o, 32'hDEADBEEF);
        idle(5'd5, 5'd0);
        #1 chk("t1_operand_a", wb.operand_a_o, 32'hDEADBEEF);
        step();

        // load x7 with a RAW reader on port B
        drive(0, 0, 5'd0, 32'd0, 1, 5'd7, 0, 0, 32'd0, 5'd0, 5'd7);
        step();
        repeat (2) begin
            idle(5'd0, 5'd7);
            #1 chk("t2_stall_wait", 32'(wb.stall_id_o), 32'd1);
            step();
        end
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0, 32'h1234, 5'd0, 5'd7);
        #1 chk("t2_stall_rsp", 32'(wb.stall_id_o), 32'd1);
        step();
        chk("t2_rf_waddr", 32'(wb.rf_waddr_o), 32'd7);
        chk("t2_rf_wdata", wb.rf_wdata_o, 32'h1234);
        idle(5'd0, 5'd7);
        #1 chk("t2_stall_after", 32'(wb.stall_id_o), 32'd0);
        chk("t2_operand_b", wb.operand_b_o, 32'h1234);
        step();

        // response and EX write of x3 collide; EX retries next cycle
        drive(0, 0, 5'd0, 32'd0, 1, 5'd3, 0, 0, 32'd0, 5'd0, 5'd0);
        step();
        drive(1, 1, 5'd3, 32'hBBBB, 0, 5'd0, 1, 0, 32'hAAAA, 5'd0, 5'd0);
        #1 chk("t3_ex_ready_rsp", 32'(wb.ex_ready_o), 32'd0);
        step();
        drive(1, 1, 5'd3, 32'hBBBB, 0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
        #1 chk("t3_ex_ready_retry", 32'(wb.ex_ready_o), 32'd1);
        chk("t3_load_wdata", wb.rf_wdata_o, 32'hAAAA);
        step();
        chk("t3_ex_wdata", wb.rf_wdata_o, 32'hBBBB);

        // WAW: EX write to x9 waits for the older load to x9
        drive(0, 0, 5'd0, 32'd0, 1, 5'd9, 0, 0, 32'd0, 5'd0, 5'd0);
        step();
        drive(1, 1, 5'd9, 32'h99, 0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
        #1 chk("t4_ex_ready_waw", 32'(wb.ex_ready_o), 32'd0);
        step();
        drive(1, 1, 5'd9, 32'h99, 0, 5'd0, 1, 0, 32'h55, 5'd0, 5'd0);
        step();
        drive(1, 1, 5'd9, 32'h99, 0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
        #1 chk("t4_ex_ready_free", 32'(wb.ex_ready_o), 32'd1);
        step();
        chk("t4_final_waddr", 32'(wb.rf_waddr_o), 32'd9);
        chk("t4_final_wdata", wb.rf_wdata_o, 32'h99);

        // error response
        drive(0, 0, 5'd0, 32'd0, 1, 5'd4, 0, 0, 32'd0, 5'd0, 5'd0);
        step();
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 1, 32'hE0E0, 5'd0, 5'd0);
        step();
        idle(5'd0, 5'd0);
        #1 chk("t5_load_err", 32'(wb.load_err_o), 32'd1);
        chk("t5_no_rf_we", 32'(wb.rf_we_o), 32'd0);
        chk("t5_busy", 32'(wb.lsu_busy_o), 32'd0);
        step();
        chk("t5_err_one_shot", 32'(wb.load_err_o), 32'd0);

        // x0 is never written and never stalls
        drive(1, 1, 5'd0, 32'h1111, 1, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
        step();
        chk("t6_ex_x0", 32'(wb.rf_we_o), 32'd0);
        idle(5'd0, 5'd0);
        #1 chk("t6_stall_x0", 32'(wb.stall_id_o), 32'd0);
        step();
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0, 32'h2222, 5'd0, 5'd0);
        step();
        chk("t6_load_x0", 32'(wb.rf_we_o), 32'd0);

        // random legal traffic
        for (int i = 0; i < 1500; i++) begin
            rv  = pend_v && ($urandom_range(0, 2) == 0);
            iss = (!pend_v || rv) && ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom, iss, 5'($urandom_range(0, 7)), rv, ($urandom_range(0, 7) == 0),
                  $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
        while (pend_v) begin
            drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0, $urandom, 5'd0, 5'd0);
            step();
        end

        // reset during WAIT_RSP clears registered outputs at once
        drive(1, 1, 5'd2, 32'h77, 1, 5'd6, 0, 0, 32'd0, 5'd0, 5'd0);
        step();
        idle(5'd0, 5'd0);
        #1 chk("t7_busy_before", 32'(wb.lsu_busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rf_we", 32'(wb.rf_we_o), 32'd0);
        chk("t7_rf_waddr", 32'(wb.rf_waddr_o), 32'd0);
        chk("t7_rf_wdata", wb.rf_wdata_o, 32'd0);
        chk("t7_busy", 32'(wb.lsu_busy_o), 32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        pend_v = 0; pend_rd = 0; fw_we = 0; exp_err = 0;
        cyc++;
        rst_n = 1'b1;
        idle(5'd6, 5'd6);
        #1 chk("t7_busy_after", 32'(wb.lsu_busy_o), 32'd0);
        chk("t7_stall_after", 32'(wb.stall_id_o), 32'd0);
        step();
        idle(5'd0, 5'd0);
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
